// File: rtl/any1_pkg.sv
// rtl/any1_pkg.sv - shared types and address decode for the any1 bus responder
package any1_pkg;

   typedef enum logic [1:0] {REG_ROM, REG_RAM, REG_NONE} region_e;

   typedef enum logic [1:0] {IDLE, WAIT, RESP, HOLD} resp_state_e;

   localparam logic [7:0] ROM_BASE_HI = 8'hFF;

   function automatic region_e decode_region(input logic [31:0] adr, input int ram_awid);
      if (adr[31:24] == ROM_BASE_HI)
         return REG_ROM;
      else if ((adr >> (ram_awid + 4)) == 32'd0)
         return REG_RAM;
      else
         return REG_NONE;
   endfunction

endpackage

// File: rtl/any1_bus_responder_if.sv
// rtl/any1_bus_responder_if.sv - wishbone-classic cyc/stb/ack bus between the any1 core and a target
interface any1_bus_responder_if;
   logic         cyc_i;
   logic         stb_i;
   logic         we_i;
   logic [15:0]  sel_i;
   logic [31:0]  adr_i;
   logic [127:0] dat_i;
   logic         vpa_i;
   logic         ack_o;
   logic         err_o;
   logic [127:0] dat_o;

   modport master (
      output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, vpa_i,
      input  ack_o, err_o, dat_o
   );

   modport slave (
      input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i, vpa_i,
      output ack_o, err_o, dat_o
   );
endinterface

// File: rtl/any1_bytelane_ram.sv
// rtl/any1_bytelane_ram.sv - 128-bit single-port RAM with 16 byte enables and registered read
module any1_bytelane_ram #(
   parameter int AWID = 9
) (
   input  logic            clk_i,
   input  logic            en_i,
   input  logic            we_i,
   input  logic [15:0]     be_i,
   input  logic [AWID-1:0] addr_i,
   input  logic [127:0]    wdata_i,
   output logic [127:0]    rdata_o
);

   logic [127:0] mem [2**AWID];

   // Read data register only updates on reads, so it stays stable across a held response.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         if (we_i) begin
            for (int i = 0; i < 16; i++) begin
               if (be_i[i])
                  mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
         end else begin
            rdata_o <= mem[addr_i];
         end
      end
   end

endmodule

// File: rtl/any1_bus_responder.sv
// rtl/any1_bus_responder.sv - wishbone target serving boot ROM and scratch RAM with wait states and error response
module any1_bus_responder
   import any1_pkg::*;
#(
   parameter int           WAIT_STATES = 0,
   parameter int           ROM_AWID    = 8,
   parameter int           RAM_AWID    = 9,
   parameter logic [127:0] FILL_WORD   = '0
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   any1_bus_responder_if.slave bus,
   input  logic                ld_we_i,
   input  logic [ROM_AWID-1:0] ld_adr_i,
   input  logic [127:0]        ld_dat_i,
   output logic [31:0]         fetch_cnt_o
);

   localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   resp_state_e         state_q, state_d;
   logic [3:0]          cnt_q, cnt_d;
   region_e             region_d, region_q;
   logic                req, bad_d, bad_q;
   logic                we_q, vpa_q;
   logic [15:0]         sel_q;
   logic [ROM_AWID-1:0] rom_idx_q;
   logic [RAM_AWID-1:0] ram_idx_q;
   logic [127:0]        wdat_q;
   logic                ack_q, err_q;
   logic [127:0]        rom_rd_q, ram_rd;
   logic                ram_en;
   logic [31:0]         fetch_q;

   logic [127:0] rom [2**ROM_AWID];

   // Array contents come from the preload port or bus writes; FILL_WORD is not applied by hardware.
   logic [127:0] unused_fill;
   assign unused_fill = FILL_WORD;

   assign req      = bus.cyc_i & bus.stb_i;
   assign region_d = decode_region(bus.adr_i, RAM_AWID);
   assign bad_d    = (region_d == REG_NONE) || ((region_d == REG_ROM) && bus.we_i);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (req) begin
               if (WAIT_STATES > 0) begin
                  state_d = WAIT;
                  cnt_d   = WS_LOAD;
               end else begin
                  state_d = RESP;
               end
            end
         end
         WAIT: begin
            if (!bus.cyc_i) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else if (cnt_q == 4'd0) begin
               state_d = RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RESP: state_d = HOLD;
         HOLD: begin
            if (!bus.stb_i || !bus.cyc_i)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         fetch_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (state_q == RESP) begin
            ack_q <= !bad_q;
            err_q <= bad_q;
            if (!bad_q && !we_q && vpa_q)
               fetch_q <= fetch_q + 32'd1;
         end else if ((state_q == HOLD) && (state_d == IDLE)) begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
         end
      end
   end

   // Request payload is captured once in IDLE and held untouched until the next accept.
   always_ff @(posedge clk_i) begin
      if ((state_q == IDLE) && req) begin
         region_q  <= region_d;
         bad_q     <= bad_d;
         we_q      <= bus.we_i;
         vpa_q     <= bus.vpa_i;
         sel_q     <= bus.sel_i;
         rom_idx_q <= bus.adr_i[ROM_AWID+3:4];
         ram_idx_q <= bus.adr_i[RAM_AWID+3:4];
         wdat_q    <= bus.dat_i;
      end
   end

   // Preload and bus read share an edge: the read register sees the old line.
   always_ff @(posedge clk_i) begin
      if (ld_we_i)
         rom[ld_adr_i] <= ld_dat_i;
      if ((state_q == RESP) && (region_q == REG_ROM))
         rom_rd_q <= rom[rom_idx_q];
   end

   assign ram_en = (state_q == RESP) && (region_q == REG_RAM);

   any1_bytelane_ram #(
      .AWID (RAM_AWID)
   ) u_ram (
      .clk_i   (clk_i),
      .en_i    (ram_en),
      .we_i    (we_q),
      .be_i    (sel_q),
      .addr_i  (ram_idx_q),
      .wdata_i (wdat_q),
      .rdata_o (ram_rd)
   );

   assign bus.ack_o   = ack_q;
   assign bus.err_o   = err_q;
   assign bus.dat_o   = (ack_q && !we_q) ? ((region_q == REG_RAM) ? ram_rd : rom_rd_q) : '0;
   assign fetch_cnt_o = fetch_q;

endmodule

// File: tb/tb_any1_bus_responder.sv
// tb/tb_any1_bus_responder.sv - self-checking bench for any1_bus_responder with zero and three wait states
module tb_any1_bus_responder;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic         rst_n;
   logic         ld_we;
   logic [7:0]   ld_adr;
   logic [127:0] ld_dat;
   logic [31:0]  fc0, fc3;

   any1_bus_responder_if b0 ();
   any1_bus_responder_if b3 ();

   any1_bus_responder #(.WAIT_STATES(0)) dut0 (
      .clk_i(clk), .rst_ni(rst_n), .bus(b0),
      .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat), .fetch_cnt_o(fc0)
   );

   any1_bus_responder #(.WAIT_STATES(3)) dut3 (
      .clk_i(clk), .rst_ni(rst_n), .bus(b3),
      .ld_we_i(ld_we), .ld_adr_i(ld_adr), .ld_dat_i(ld_dat), .fetch_cnt_o(fc3)
   );

   int nchk = 0;
   int nerr = 0;

   logic [127:0] rom_m [256];
   logic [127:0] ram_m [2][512];
   int unsigned  fetch_m [2];

   localparam logic [127:0] C0 = 128'h0123_4567_89AB_CDEF_0011_2233_4455_6677;

   typedef struct {
      logic         we;
      logic [15:0]  sel;
      logic [31:0]  adr;
      logic [127:0] dat;
      logic         vpa;
      int           hold;
      logic         e_ack;
      logic         e_err;
      logic [127:0] e_dat;
   } vec_t;

   vec_t tv [15];

   task automatic chk(input string nm, input logic [129:0] got, input logic [129:0] exp);
      nchk++;
      if (got !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask

   function automatic logic [127:0] rom_val(input int i);
      logic [31:0] t;
      t = 32'h5A5A_0000 + 32'(i);
      return (i == 0) ? C0 : {t, ~t, t, ~t};
   endfunction

   // w: 0 selects the zero-wait responder, 1 the three-wait one.
   task automatic drive(input int w, input logic cyc, input logic stb, input logic we,
                        input logic [15:0] sel, input logic [31:0] adr, input logic [127:0] dat,
                        input logic vpa);
      if (w == 0) begin
         b0.cyc_i = cyc; b0.stb_i = stb; b0.we_i = we; b0.sel_i = sel;
         b0.adr_i = adr; b0.dat_i = dat; b0.vpa_i = vpa;
      end else begin
         b3.cyc_i = cyc; b3.stb_i = stb; b3.we_i = we; b3.sel_i = sel;
         b3.adr_i = adr; b3.dat_i = dat; b3.vpa_i = vpa;
      end
   endtask

   function automatic logic [129:0] sample(input int w);
      if (w == 0) return {b0.ack_o, b0.err_o, b0.dat_o};
      return {b3.ack_o, b3.err_o, b3.dat_o};
   endfunction

   task automatic idle(input int w);
      drive(w, 1'b0, 1'b0, 1'b0, '0, '0, '0, 1'b0);
   endtask

   // Reference: decode by address range, byte-lane merge, fetch counting.
   task automatic model(input int w, input logic we, input logic [15:0] sel, input logic [31:0] adr,
                        input logic [127:0] dat, input logic vpa,
                        output logic e_ack, output logic e_err, output logic [127:0] e_dat);
      int rgn;
      int rl, ml;
      rl  = int'(adr[11:4]);
      ml  = int'(adr[12:4]);
      rgn = (adr >= 32'hFF00_0000) ? 0 : (adr < 32'h0000_2000) ? 1 : 2;
      e_err = (rgn == 2) || (rgn == 0 && we);
      e_ack = !e_err;
      e_dat = '0;
      if (e_ack && !we) begin
         e_dat = (rgn == 0) ? rom_m[rl] : ram_m[w][ml];
         if (vpa) fetch_m[w]++;
      end
      if (e_ack && we) begin
         for (int i = 0; i < 16; i++)
            if (sel[i]) ram_m[w][ml][8*i +: 8] = dat[8*i +: 8];
      end
   endtask

   task automatic xfer(input int w, input logic we, input logic [15:0] sel, input logic [31:0] adr,
                       input logic [127:0] dat, input logic vpa, input int hold,
                       output logic g_ack, output logic g_err, output logic [127:0] g_dat,
                       output int edges);
      logic [129:0] s, s2;
      @(negedge clk);
      drive(w, 1'b1, 1'b1, we, sel, adr, dat, vpa);
      edges = 0;
      s = '0;
      while (edges < 40 && s[129:128] == 2'b00) begin
         @(posedge clk); #1;
         edges++;
         s = sample(w);
      end
      g_ack = s[129];
      g_err = s[128];
      g_dat = s[127:0];
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_stable", sample(w), s);
      end
      @(negedge clk);
      idle(w);
      @(posedge clk); #1;
      s2 = sample(w);
      chk("release_after_stb", s2, '0);
   endtask

   task automatic txn(input string nm, input int w, input logic we, input logic [15:0] sel,
                      input logic [31:0] adr, input logic [127:0] dat, input logic vpa, input int hold,
                      input logic e_ack, input logic e_err, input logic [127:0] e_dat);
      logic ga, ge;
      logic [127:0] gd;
      int ed;
      xfer(w, we, sel, adr, dat, vpa, hold, ga, ge, gd, ed);
      chk({nm, "_ack"}, ga, e_ack);
      chk({nm, "_err"}, ge, e_err);
      chk({nm, "_latency"}, ed, (w == 0) ? 2 : 5);
      if (e_ack && !we) chk({nm, "_dat"}, gd, e_dat);
   endtask

   task automatic mtxn(input string nm, input int w, input logic we, input logic [15:0] sel,
                       input logic [31:0] adr, input logic [127:0] dat, input logic vpa, input int hold);
      logic ea, ee;
      logic [127:0] edat;
      model(w, we, sel, adr, dat, vpa, ea, ee, edat);
      txn(nm, w, we, sel, adr, dat, vpa, hold, ea, ee, edat);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1);
   end

   initial begin
      logic ea, ee, any;
      logic [127:0] edat, old5, new5;
      logic [129:0] s;

      rst_n = 1'b0; ld_we = 1'b0; ld_adr = '0; ld_dat = '0;
      idle(0); idle(1);
      fetch_m[0] = 0; fetch_m[1] = 0;
      repeat (2) @(posedge clk);
      #1;
      s = sample(0); chk("reset_ack0", s[129], 0); chk("reset_err0", s[128], 0); chk("reset_dat0", s[127:0], 0);
      s = sample(1); chk("reset_ack3", s[129], 0); chk("reset_err3", s[128], 0); chk("reset_dat3", s[127:0], 0);
      chk("reset_fetch0", fc0, 0);
      chk("reset_fetch3", fc3, 0);
      @(negedge clk) rst_n = 1'b1;

      for (int i = 0; i < 256; i++) begin
         @(negedge clk);
         ld_we = 1'b1; ld_adr = 8'(i); ld_dat = rom_val(i);
         rom_m[i] = rom_val(i);
      end
      @(negedge clk) ld_we = 1'b0;

      for (int w = 0; w < 2; w++)
         for (int l = 0; l < 16; l++)
            mtxn("ram_init", w, 1'b1, 16'hFFFF, 32'(l) << 4, '0, 1'b0, 0);

      tv[0]  = '{1'b0, 16'h0000, 32'hFF00_0000, '0, 1'b1, 0, 1'b1, 1'b0, C0};
      tv[1]  = '{1'b1, 16'h00FF, 32'h0000_0010, {16{8'hAA}}, 1'b0, 0, 1'b1, 1'b0, '0};
      tv[2]  = '{1'b0, 16'h0000, 32'h0000_0010, '0, 1'b0, 4, 1'b1, 1'b0,
                 128'h0000_0000_0000_0000_AAAA_AAAA_AAAA_AAAA};
      tv[3]  = '{1'b0, 16'hFFFF, 32'h1000_0000, '0, 1'b0, 0, 1'b0, 1'b1, '0};
      tv[4]  = '{1'b1, 16'hFFFF, 32'hFF00_0020, {16{8'h33}}, 1'b0, 0, 1'b0, 1'b1, '0};
      tv[5]  = '{1'b0, 16'h0000, 32'hFF00_0020, '0, 1'b1, 1, 1'b1, 1'b0, rom_val(2)};
      tv[6]  = '{1'b1, 16'hFFFF, 32'h0000_1FF0, 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0, 1'b0, 0, 1'b1, 1'b0, '0};
      tv[7]  = '{1'b0, 16'h0000, 32'h0000_1FF0, '0, 1'b0, 0, 1'b1, 1'b0,
                 128'hDEAD_BEEF_0BAD_F00D_1234_5678_9ABC_DEF0};
      tv[8]  = '{1'b0, 16'hFFFF, 32'h0000_2000, '0, 1'b0, 0, 1'b0, 1'b1, '0};
      tv[9]  = '{1'b1, 16'hFFFF, 32'h0000_2000, {16{8'h77}}, 1'b0, 0, 1'b0, 1'b1, '0};
      tv[10] = '{1'b0, 16'h0000, 32'hFFFF_FFF0, '0, 1'b0, 0, 1'b1, 1'b0, rom_val(255)};
      tv[11] = '{1'b0, 16'h0000, 32'hFEFF_FFF0, '0, 1'b1, 0, 1'b0, 1'b1, '0};
      tv[12] = '{1'b0, 16'h0000, 32'h0000_001F, '0, 1'b0, 0, 1'b1, 1'b0,
                 128'h0000_0000_0000_0000_AAAA_AAAA_AAAA_AAAA};
      tv[13] = '{1'b1, 16'h8001, 32'h0000_0010, {16{8'h55}}, 1'b0, 2, 1'b1, 1'b0, '0};
      tv[14] = '{1'b0, 16'h0000, 32'h0000_0010, '0, 1'b0, 0, 1'b1, 1'b0,
                 128'h5500_0000_0000_0000_AAAA_AAAA_AAAA_AA55};

      for (int i = 0; i < 15; i++) begin
         model(0, tv[i].we, tv[i].sel, tv[i].adr, tv[i].dat, tv[i].vpa, ea, ee, edat);
         txn($sformatf("vec%0d", i), 0, tv[i].we, tv[i].sel, tv[i].adr, tv[i].dat, tv[i].vpa,
             tv[i].hold, tv[i].e_ack, tv[i].e_err, tv[i].e_dat);
      end

      // Preload lands on the same edge as the bus read of that line.
      old5 = rom_m[5];
      new5 = ~old5;
      @(negedge clk) drive(0, 1'b1, 1'b1, 1'b0, '0, 32'hFF00_0050, '0, 1'b0);
      @(posedge clk);
      @(negedge clk) begin ld_we = 1'b1; ld_adr = 8'd5; ld_dat = new5; end
      @(posedge clk); #1;
      s = sample(0);
      chk("collide_ack", s[129], 1);
      chk("collide_old_dat", s[127:0], old5);
      @(negedge clk) begin ld_we = 1'b0; idle(0); end
      rom_m[5] = new5;
      @(posedge clk);
      mtxn("collide_after", 0, 1'b0, '0, 32'hFF00_0050, '0, 1'b0, 0);

      mtxn("ws3_read", 1, 1'b0, '0, 32'h0000_0010, '0, 1'b0, 0);

      // Abort in WAIT: no response, no write.
      @(negedge clk) drive(1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h0000_0020, {16{8'hFF}}, 1'b0);
      @(posedge clk);
      @(negedge clk) idle(1);
      any = 1'b0;
      repeat (6) begin
         @(posedge clk); #1;
         s = sample(1);
         if (s[129:128] != 2'b00) any = 1'b1;
      end
      chk("abort_no_resp", any, 0);
      mtxn("abort_readback", 1, 1'b0, '0, 32'h0000_0020, '0, 1'b0, 0);

      // Reset while WAIT holds a pending write.
      @(negedge clk) drive(1, 1'b1, 1'b1, 1'b1, 16'hFFFF, 32'h0000_0030, {16{8'hF0}}, 1'b0);
      @(posedge clk);
      @(negedge clk) begin rst_n = 1'b0; idle(1); end
      @(negedge clk) rst_n = 1'b1;
      fetch_m[0] = 0; fetch_m[1] = 0;
      mtxn("rst_wait_readback", 1, 1'b0, '0, 32'h0000_0030, '0, 1'b0, 0);

      // Reset while HOLD: outputs clear without waiting for an edge.
      @(negedge clk) drive(0, 1'b1, 1'b1, 1'b0, '0, 32'h0000_0010, '0, 1'b0);
      @(posedge clk);
      @(posedge clk); #1;
      s = sample(0);
      chk("hold_before_rst_ack", s[129], 1);
      #2 rst_n = 1'b0;
      #1;
      s = sample(0);
      chk("rst_hold_ack", s[129], 0);
      chk("rst_hold_dat", s[127:0], 0);
      @(negedge clk) begin idle(0); rst_n = 1'b1; end
      fetch_m[0] = 0; fetch_m[1] = 0;
      mtxn("rst_ram_keep", 0, 1'b0, '0, 32'h0000_0010, '0, 1'b0, 0);

      for (int i = 0; i < 10; i++)
         mtxn("fetch_vpa", 0, 1'b0, '0, 32'hFF00_0000 | (32'($urandom_range(0, 255)) << 4), '0, 1'b1, 0);
      for (int i = 0; i < 3; i++)
         mtxn("fetch_novpa", 0, 1'b0, '0, 32'hFF00_0000 | (32'($urandom_range(0, 255)) << 4), '0, 1'b0, 0);
      chk("fetch_cnt_10", fc0, 10);

      for (int k = 0; k < 60; k++) begin
         int w, r;
         logic [31:0] a;
         w = $urandom_range(0, 1);
         r = $urandom_range(0, 2);
         if (r == 0)      a = 32'hFF00_0000 | (32'($urandom_range(0, 255)) << 4) | 32'($urandom_range(0, 15));
         else if (r == 1) a = (32'($urandom_range(0, 15)) << 4) | 32'($urandom_range(0, 15));
         else             a = $urandom_range(32'h0000_2000, 32'hFEFF_FFFF);
         mtxn("rand", w, 1'($urandom), 16'($urandom), a,
              {$urandom, $urandom, $urandom, $urandom}, 1'($urandom), $urandom_range(0, 2));
      end
      chk("final_fetch0", fc0, fetch_m[0]);
      chk("final_fetch3", fc3, fetch_m[1]);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
